// File: rtl/forno_pkg.sv
// Shared definitions for the microwave cook sequencer: state encoding,
// BCD digit width, default quick-start time and the BCD countdown step.
package forno_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned BCD_W              = 4;
  localparam logic [15:0] DEFAULT_QUICK_SECS = 16'h0030;

  // One-second step of the {m1,m0,s1,s0} display; seconds 60-99 count literally
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else if (t[7:4] != 4'd0) begin
      r[7:4] = t[7:4] - 4'd1;
      r[3:0] = 4'd9;
    end else if (t[11:8] != 4'd0) begin
      r[11:8] = t[11:8] - 4'd1;
      r[7:4]  = 4'd5;
      r[3:0]  = 4'd9;
    end else if (t[15:12] != 4'd0) begin
      r[15:12] = t[15:12] - 4'd1;
      r[11:8]  = 4'd9;
      r[7:4]   = 4'd5;
      r[3:0]   = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_countdown.sv
// Four-digit BCD cook-time register: clear, load, keypad shift-in and
// one-second decrement, with a zero flag for the sequencer.
module bcd_countdown
  import forno_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               clr,
  input  logic               load,
  input  logic [4*BCD_W-1:0] load_val,
  input  logic               shift,
  input  logic [BCD_W-1:0]   digit,
  input  logic               dec,
  output logic [4*BCD_W-1:0] time_bcd,
  output logic               zero
);

  logic [4*BCD_W-1:0] time_d, time_q;

  // Next time value; clear dominates load, load dominates keypad and countdown
  always_comb begin
    time_d = time_q;
    if (clr) begin
      time_d = '0;
    end else if (load) begin
      time_d = load_val;
    end else if (shift) begin
      time_d = {time_q[3*BCD_W-1:0], digit};
    end else if (dec) begin
      time_d = bcd_dec(time_q);
    end
  end

  // Time register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      time_q <= '0;
    end else begin
      time_q <= time_d;
    end
  end

  assign time_bcd = time_q;
  assign zero     = (time_q == '0);

endmodule

// File: rtl/controle_forno.sv
// Microwave cook-cycle sequencer: synchronizes operator controls, runs the
// MM:SS countdown and drives the magnetron and done indication.
// Optional build macro CONTROLE_FORNO_BEEP_EN adds the beep output and its
// BEEP_CYCLES-long pulse counter.
module controle_forno
  import forno_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 1000,
  parameter logic [15:0] QUICK_SECS  = DEFAULT_QUICK_SECS
`ifdef CONTROLE_FORNO_BEEP_EN
  ,
  parameter int unsigned BEEP_CYCLES = 3000
`endif
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        startn,
  input  logic        stopn,
  input  logic        clearn,
  input  logic        door_closed,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  output logic        mag_on,
  output logic        done,
  output logic [2:0]  state,
  output logic [15:0] time_bcd
`ifdef CONTROLE_FORNO_BEEP_EN
  ,
  output logic        beep
`endif
);

  localparam int unsigned        PRESC_W    = $clog2(CLK_PER_SEC);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_SEC - 1);

  // Button order in the vectors below: {clear, stop, start}
  logic [2:0] btn_s1_q, btn_s2_q, btn_prev_q;
  logic       door_s1_q, door_s2_q, door_prev_q;

  state_e             state_d, state_q;
  logic [PRESC_W-1:0] presc_d, presc_q;
  logic               mag_on_q, done_q;

  logic        tm_clr, tm_load, tm_shift, tm_dec, tm_zero;
  logic [15:0] tm_value;

  logic press_start, press_stop, press_clear, door_ok, door_fall, key_ok;

  // Two-stage synchronizers plus previous-sample stage for edge detection
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      btn_s1_q    <= '1;
      btn_s2_q    <= '1;
      btn_prev_q  <= '1;
      door_s1_q   <= 1'b0;
      door_s2_q   <= 1'b0;
      door_prev_q <= 1'b0;
    end else begin
      btn_s1_q    <= {clearn, stopn, startn};
      btn_s2_q    <= btn_s1_q;
      btn_prev_q  <= btn_s2_q;
      door_s1_q   <= door_closed;
      door_s2_q   <= door_s1_q;
      door_prev_q <= door_s2_q;
    end
  end

  assign press_start = btn_prev_q[0] & ~btn_s2_q[0];
  assign press_stop  = btn_prev_q[1] & ~btn_s2_q[1];
  assign press_clear = btn_prev_q[2] & ~btn_s2_q[2];
  assign door_ok     = door_s2_q;
  assign door_fall   = door_prev_q & ~door_s2_q;
  assign key_ok      = key_valid && (key_digit <= 4'd9);

  bcd_countdown u_timer (
    .clock    (clock),
    .resetn   (resetn),
    .clr      (tm_clr),
    .load     (tm_load),
    .load_val (QUICK_SECS),
    .shift    (tm_shift),
    .digit    (key_digit),
    .dec      (tm_dec),
    .time_bcd (tm_value),
    .zero     (tm_zero)
  );

  // Sequencer next state with priority clear > stop > door open > start > key
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tm_clr   = 1'b0;
    tm_load  = 1'b0;
    tm_shift = 1'b0;
    tm_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_clear || press_stop) begin
          tm_clr = 1'b1;
        end else if (press_start && door_ok) begin
          tm_load = 1'b1;
          presc_d = '0;
          state_d = ST_COOK;
        end else if (key_ok) begin
          tm_shift = 1'b1;
          state_d  = ST_SET;
        end
      end
      ST_SET: begin
        if (press_clear || press_stop) begin
          tm_clr  = 1'b1;
          state_d = ST_IDLE;
        end else if (press_start && door_ok) begin
          tm_load = tm_zero;
          presc_d = '0;
          state_d = ST_COOK;
        end else if (key_ok) begin
          tm_shift = 1'b1;
        end
      end
      ST_COOK: begin
        if (press_clear) begin
          tm_clr  = 1'b1;
          state_d = ST_IDLE;
        end else if (press_stop || !door_ok) begin
          state_d = ST_PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tm_dec  = 1'b1;
          // Only 0001 decrements to 0000, so finish on that edge
          if (tm_value == 16'h0001) begin
            state_d = ST_DONE;
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
      ST_PAUSE: begin
        if (press_clear || press_stop) begin
          tm_clr  = 1'b1;
          state_d = ST_IDLE;
        end else if (press_start && door_ok) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (press_clear || press_stop || press_start || door_fall) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, prescaler and registered magnetron/done outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      mag_on_q <= (state_d == ST_COOK);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign mag_on   = mag_on_q;
  assign done     = done_q;
  assign state    = state_q;
  assign time_bcd = tm_value;

`ifdef CONTROLE_FORNO_BEEP_EN
  localparam int unsigned BEEP_W = $clog2(BEEP_CYCLES + 1);

  logic              beep_d, beep_q;
  logic [BEEP_W-1:0] beep_cnt_d, beep_cnt_q;

  // Beep pulse starts on DONE entry, ends after BEEP_CYCLES or on DONE exit
  always_comb begin
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      beep_d     = 1'b1;
      beep_cnt_d = BEEP_W'(BEEP_CYCLES - 1);
    end else if (state_d != ST_DONE) begin
      beep_d     = 1'b0;
      beep_cnt_d = '0;
    end else if (beep_q) begin
      if (beep_cnt_q == '0) begin
        beep_d = 1'b0;
      end else begin
        beep_cnt_d = beep_cnt_q - BEEP_W'(1);
      end
    end
  end

  // Beep registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else begin
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign beep = beep_q;
`endif

endmodule

// File: tb/tb_controle_forno.sv
// Bench for controle_forno: directed scenarios plus randomized operator
// activity, checked every cycle against a behavioural cook-cycle model.
module tb_controle_forno;

  localparam int CPS       = 4;
  localparam int BEEPC     = 20;
  localparam int QUICK_VAL = 30;
  localparam int S_IDLE = 0, S_SET = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door_closed = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        mag_on, done;
  logic [2:0]  state;
  logic [15:0] time_bcd;
`ifdef CONTROLE_FORNO_BEEP_EN
  logic        beep;
`endif

  int errors = 0;
  int checks = 0;

  // Model: state code, time as 4-digit decimal MMSS, prescaler, beep cycles left
  int m_st, m_val, m_presc, m_bl;
  // Pin history: [0]=sampled last edge, [1]=two edges ago, [2]=three edges ago
  logic [2:0] h_start, h_stop, h_clear, h_door;

  controle_forno #(
    .CLK_PER_SEC (CPS)
`ifdef CONTROLE_FORNO_BEEP_EN
    ,
    .BEEP_CYCLES (BEEPC)
`endif
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .mag_on      (mag_on),
    .done        (done),
    .state       (state),
    .time_bcd    (time_bcd)
`ifdef CONTROLE_FORNO_BEEP_EN
    ,
    .beep        (beep)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return 16'((((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
               (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    m_st    = S_IDLE;
    m_val   = 0;
    m_presc = 0;
    m_bl    = 0;
    h_start = 3'b111;
    h_stop  = 3'b111;
    h_clear = 3'b111;
    h_door  = 3'b000;
  endtask

  task automatic model_step();
    bit pc, ps, pst, dlvl, dfall, kok;
    int prev;
    pc    = h_clear[2] & ~h_clear[1];
    ps    = h_stop[2]  & ~h_stop[1];
    pst   = h_start[2] & ~h_start[1];
    dlvl  = h_door[1];
    dfall = h_door[2] & ~h_door[1];
    kok   = key_valid && (key_digit <= 4'd9);
    prev  = m_st;
    case (m_st)
      S_IDLE: begin
        if (pc || ps) m_val = 0;
        else if (pst && dlvl) begin m_val = QUICK_VAL; m_presc = 0; m_st = S_COOK; end
        else if (kok) begin m_val = (m_val * 10 + int'(key_digit)) % 10000; m_st = S_SET; end
      end
      S_SET: begin
        if (pc || ps) begin m_val = 0; m_st = S_IDLE; end
        else if (pst && dlvl) begin
          if (m_val == 0) m_val = QUICK_VAL;
          m_presc = 0;
          m_st = S_COOK;
        end
        else if (kok) m_val = (m_val * 10 + int'(key_digit)) % 10000;
      end
      S_COOK: begin
        if (pc) begin m_val = 0; m_st = S_IDLE; end
        else if (ps || !dlvl) m_st = S_PAUSE;
        else if (m_presc == CPS - 1) begin
          m_presc = 0;
          if (m_val % 100 > 0) m_val = m_val - 1;
          else m_val = (m_val / 100 - 1) * 100 + 59;
          if (m_val == 0) m_st = S_DONE;
        end
        else m_presc++;
      end
      S_PAUSE: begin
        if (pc || ps) begin m_val = 0; m_st = S_IDLE; end
        else if (pst && dlvl) m_st = S_COOK;
      end
      default: begin
        if (pc || ps || pst || dfall) m_st = S_IDLE;
      end
    endcase
    if (m_st == S_DONE && prev != S_DONE) m_bl = BEEPC;
    else if (m_st != S_DONE) m_bl = 0;
    else if (m_bl > 0) m_bl--;
    h_start = {h_start[1:0], startn};
    h_stop  = {h_stop[1:0], stopn};
    h_clear = {h_clear[1:0], clearn};
    h_door  = {h_door[1:0], door_closed};
  endtask

  always @(posedge clock) begin
    if (!resetn) model_reset();
    else model_step();
  end

  always @(negedge clock) begin
    if (resetn) begin
      check_eq("state", 32'(state), 32'(m_st));
      check_eq("time_bcd", 32'(time_bcd), 32'(to_bcd(m_val)));
      check_eq("mag_on", 32'(mag_on), 32'(m_st == S_COOK));
      check_eq("done", 32'(done), 32'(m_st == S_DONE));
`ifdef CONTROLE_FORNO_BEEP_EN
      check_eq("beep", 32'(beep), 32'(m_bl > 0));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // 0=start, 1=stop, 2=clear; held for two cycles then released
  task automatic press_btn(input int which);
    case (which)
      0: startn = 1'b0;
      1: stopn  = 1'b0;
      default: clearn = 1'b0;
    endcase
    tick(2);
    startn = 1'b1;
    stopn  = 1'b1;
    clearn = 1'b1;
  endtask

  task automatic key(input int d);
    key_valid = 1'b1;
    key_digit = 4'(d);
    tick(1);
    key_valid = 1'b0;
    tick(1);
  endtask

  task automatic wait_state(input int s, input int maxc, input string tag);
    int n;
    n = 0;
    while (int'(state) != s && n < maxc) begin
      @(negedge clock);
      n++;
    end
    check_eq(tag, 32'(state), 32'(s));
  endtask

  initial begin
    model_reset();
    tick(2);
    check_eq("rst_state", 32'(state), 32'(S_IDLE));
    check_eq("rst_time", 32'(time_bcd), 32'h0);
    check_eq("rst_mag", 32'(mag_on), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    resetn = 1'b1;
    tick(4);

    // Basic cook to completion
    key(1);
    key(2);
    check_eq("keys_12", 32'(time_bcd), 32'h0012);
    press_btn(0);
    wait_state(S_COOK, 10, "cook_a");
    wait_state(S_DONE, 100, "done_a");
    check_eq("done_flag", 32'(done), 32'h1);
    check_eq("done_mag", 32'(mag_on), 32'h0);
    tick(3);
    press_btn(1);
    wait_state(S_IDLE, 10, "done_exit");

    // Minute borrow, key ignored in COOK, door pause and resume
    key(1);
    key(0);
    key(0);
    check_eq("keys_100", 32'(time_bcd), 32'h0100);
    press_btn(0);
    wait_state(S_COOK, 10, "cook_b");
    tick(6);
    check_eq("dec_0059", 32'(time_bcd), 32'h0059);
    key(9);
    door_closed = 1'b0;
    tick(3);
    check_eq("door_mag_off", 32'(mag_on), 32'h0);
    check_eq("door_pause", 32'(state), 32'(S_PAUSE));
    tick(5);
    door_closed = 1'b1;
    tick(4);
    press_btn(0);
    wait_state(S_COOK, 10, "resume");
    tick(10);
    press_btn(2);
    wait_state(S_IDLE, 10, "clear_cook");

    // Quick start, and start with door open
    press_btn(0);
    wait_state(S_COOK, 10, "quick_cook");
    check_eq("quick_time", 32'(time_bcd), 32'h0030);
    press_btn(2);
    wait_state(S_IDLE, 10, "quick_clear");
    door_closed = 1'b0;
    tick(4);
    press_btn(0);
    tick(3);
    check_eq("start_door_open", 32'(state), 32'(S_IDLE));
    door_closed = 1'b1;
    tick(4);

    // Clear and start together in SET
    key(5);
    clearn = 1'b0;
    startn = 1'b0;
    tick(2);
    clearn = 1'b1;
    startn = 1'b1;
    tick(2);
    check_eq("set_clr_state", 32'(state), 32'(S_IDLE));
    check_eq("set_clr_time", 32'(time_bcd), 32'h0);

    // Short cook to DONE, dwell for the beep window, leave by door opening
    key(2);
    press_btn(0);
    wait_state(S_DONE, 40, "done_b");
    tick(BEEPC + 5);
    door_closed = 1'b0;
    tick(4);
    check_eq("door_exit_done", 32'(state), 32'(S_IDLE));
    door_closed = 1'b1;
    tick(4);

    // Randomized operator activity
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      startn = (startn == 1'b0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) != 0);
      stopn  = (stopn  == 1'b0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 199) != 0);
      clearn = (clearn == 1'b0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 149) == 0) door_closed = ~door_closed;
      key_valid = ($urandom_range(0, 7) == 0);
      key_digit = 4'($urandom_range(0, 15));
    end
    @(negedge clock);
    startn = 1'b1;
    stopn = 1'b1;
    clearn = 1'b1;
    door_closed = 1'b1;
    key_valid = 1'b0;
    tick(5);
    press_btn(2);
    wait_state(S_IDLE, 10, "rand_clear");

    // Asynchronous reset in the middle of COOK
    key(3);
    press_btn(0);
    wait_state(S_COOK, 10, "cook_c");
    tick(2);
    #3;
    resetn = 1'b0;
    #1;
    check_eq("arst_state", 32'(state), 32'(S_IDLE));
    check_eq("arst_time", 32'(time_bcd), 32'h0);
    check_eq("arst_mag", 32'(mag_on), 32'h0);
    check_eq("arst_done", 32'(done), 32'h0);
    tick(2);
    resetn = 1'b1;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
